frame_out_sched: RTL and testbench
==================================

Name: frame_out_sched

Overview:
- Shares the single frame-output framer (header + payload + blank-gap sequencer) among N_CH source FIFOs.
- Picks one eligible channel per frame and presents that channel's FIFO fill level and read data to the framer.
- Routes the framer's read-acknowledge back to the chosen FIFO as its read request.
- Holds the grant from frame start to frame end, and gates the whole channel with start/stop controls.

Parameters:
- N_CH, 4, number of source FIFO channels (2..8)
- DW, 16, data word width
- NUM_W, 13, FIFO fill-count width
- TMO_CYC, 1024, max cycles from grant to framer en_out rising before the grant is abandoned

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_en  in  1  run request, level, asynchronous to clk
- stop_en  in  1  stop request, level, asynchronous to clk
- frame_length  in  16  payload words per frame, same value the framer uses
- ch_enable  in  N_CH  per-channel participation mask
- ch_rdnum  in  N_CH*NUM_W  per-channel FIFO fill counts; channel i occupies bits [i*NUM_W +: NUM_W]
- ch_dat  in  N_CH*DW  per-channel FIFO read data, packed the same way
- ch_rdreq  out  N_CH  per-channel FIFO read request
- fr_rdacq  in  1  framer read acknowledge
- fr_en_out  in  1  framer output-valid
- fr_rdnum  out  NUM_W  fill count forwarded to the framer
- fr_dat  out  DW  data forwarded to the framer
- grant_id  out  3  currently or last granted channel index
- busy  out  1  a frame is in flight
- tmo_err  out  1  one-cycle pulse on grant timeout
- frame_cnt  out  16  frames completed, wraps at 0xFFFF->0

Behaviour:
- Reset values: ch_rdreq=0, fr_rdnum=0, grant_id=0, busy=0, tmo_err=0, frame_cnt=0, run=0, state=IDLE, last_grant=N_CH-1 (so the first grant goes to ch0).
- start_en and stop_en each pass through a 2-FF synchronizer.
  - Rising edge of synced start sets run; rising edge of synced stop clears it.
  - Simultaneous rising edges: stop wins.
- elig[i] is registered: ch_enable[i] && (ch_rdnum[i] >= frame_length), compared zero-extended to 16 bits. This adds one cycle of latency.
- FSM states: IDLE, ARB, GRANT, BUSY, DONE.
  - IDLE: forward nothing. Go to ARB when run=1.
  - ARB: if run=0, go to IDLE. If any elig bit is set, pick a channel round-robin, searching from last_grant+1 with wrap modulo N_CH. Register grant_id and last_grant, then go to GRANT. If no elig bit is set, stay in ARB.
  - GRANT: start a timeout counter. On fr_en_out rising, go to BUSY with busy=1. If TMO_CYC cycles elapse without it, pulse tmo_err for 1 cycle and go to ARB; last_grant has already advanced, so the same channel is not immediately regranted.
  - BUSY: hold the grant and ignore run changes. On fr_en_out falling, go to DONE. A stop request mid-frame never truncates the frame.
  - DONE: busy=0, frame_cnt+1. Go to ARB if run=1, otherwise IDLE.
- Forwarding:
  - fr_rdnum = ch_rdnum[grant_id] in GRANT/BUSY; 0 in every other state, so the framer cannot start unowned.
  - fr_dat = ch_dat[grant_id], combinational, zero-latency relative to the FIFO output.
  - ch_rdreq[i] = fr_rdacq && (i==grant_id) && state in {GRANT, BUSY}. It is never asserted on more than one channel.
- If ch_enable of the granted channel drops mid-frame, the frame still completes; eligibility applies only at arbitration.
- The framer's blank gap (>=1 cycle) covers the 1-cycle lag between DONE and the next grant. The block must be correct for blank_length=0.
- Reset mid-frame returns everything to reset values immediately; FIFO contents are untouched.

Optional Feature:
- Macro: FRAME_OUT_SCHED_STRICT_PRIO_EN.
- When defined: ARB uses fixed priority, lowest index eligible channel wins, and last_grant is ignored.
- When undefined: round-robin as above.
- All ports are identical in both builds.

Decomposition:
- Package frame_out_pkg holds:
  - HEAD0=16'h1ACF and HEAD1=16'hFC1D
  - the FSM state enum
  - default DW/NUM_W widths
- One sub-module, frame_rr_arb: input N_CH request vector plus last_grant, output index and valid. It is purely combinational. The STRICT_PRIO macro is handled inside it.

Test Plan:
- run=1, all 4 channels full (rdnum=200, frame_length=100) -> grants ch0,1,2,3,0 in order; frame_cnt=5 after 5 frames; ch_rdreq one-hot and equal to fr_rdacq.
- Only ch2 has rdnum>=frame_length, ch_enable=4'b1011 -> no grant; set ch_enable=4'b1111 -> grant_id=2 within 3 cycles.
- stop_en rises during BUSY -> frame completes (fr_en_out falls normally), DONE, then IDLE; no further grants; fr_rdnum=0.
- Framer held with fr_en_out=0, TMO_CYC=16 -> tmo_err pulses exactly once 16 cycles after grant; next grant goes to the following channel.
- Same-cycle rising start/stop -> run stays 0. reset_n low during BUSY -> all outputs 0 on the next edge.
- With FRAME_OUT_SCHED_STRICT_PRIO_EN, ch0 and ch3 continuously eligible -> ch0 granted every frame.

Source files
------------

// File: rtl/frame_out_pkg.sv
// Shared constants, default widths and FSM encoding for the frame-output scheduler.
// Pure declarations: no logic, no latency, no flow control.
package frame_out_pkg;
   localparam logic [15:0] HEAD0 = 16'h1ACF;
   localparam logic [15:0] HEAD1 = 16'hFC1D;

   localparam int DEF_DW    = 16;
   localparam int DEF_NUM_W = 13;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_GRANT,
      ST_BUSY,
      ST_DONE
   } sched_state_t;
endpackage

// File: rtl/frame_rr_arb.sv
// Combinational channel picker: round-robin from i_last+1, or lowest index when
// FRAME_OUT_SCHED_STRICT_PRIO_EN is defined. Zero latency, no flow control.
module frame_rr_arb
   import frame_out_pkg::*;
#(
   parameter int N_CH = 4
)(
   input  logic [N_CH-1:0] i_req,
   input  logic [2:0]      i_last,
   output logic [2:0]      o_idx,
   output logic            o_vld
);

`ifdef FRAME_OUT_SCHED_STRICT_PRIO_EN
   logic w_unused_last;
   assign w_unused_last = ^i_last;

   // Scan from the top down so the lowest requesting index is written last and wins.
   always_comb begin
      o_vld = 1'b0;
      o_idx = 3'd0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_vld = 1'b1;
            o_idx = 3'(i);
         end
      end
   end
`else
   // Farthest rotation distance first, so distance 1 (i_last+1) is written last and wins.
   always_comb begin
      o_vld = 1'b0;
      o_idx = 3'd0;
      for (int k = N_CH; k >= 1; k--) begin
         for (int i = 0; i < N_CH; i++) begin
            if (i_req[i] && (((int'(i_last) + k) % N_CH) == i)) begin
               o_vld = 1'b1;
               o_idx = 3'(i);
            end
         end
      end
   end
`endif

endmodule

// File: rtl/frame_out_sched.sv
// Shares one framer among N_CH FIFOs; grant 2 cycles after eligibility, held start-to-end of frame,
// no backpressure beyond the framer's rdacq. FRAME_OUT_SCHED_STRICT_PRIO_EN selects fixed priority.
module frame_out_sched
   import frame_out_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int DW      = DEF_DW,
   parameter int NUM_W   = DEF_NUM_W,
   parameter int TMO_CYC = 1024
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_en,
   input  logic                  stop_en,
   input  logic [15:0]           frame_length,
   input  logic [N_CH-1:0]       ch_enable,
   input  logic [N_CH*NUM_W-1:0] ch_rdnum,
   input  logic [N_CH*DW-1:0]    ch_dat,
   output logic [N_CH-1:0]       ch_rdreq,
   input  logic                  fr_rdacq,
   input  logic                  fr_en_out,
   output logic [NUM_W-1:0]      fr_rdnum,
   output logic [DW-1:0]         fr_dat,
   output logic [2:0]            grant_id,
   output logic                  busy,
   output logic                  tmo_err,
   output logic [15:0]           frame_cnt
);
   localparam int TW = $clog2(TMO_CYC + 1);

   logic [1:0]       r_start_sync;
   logic [1:0]       r_stop_sync;
   logic             r_start_d;
   logic             r_stop_d;
   logic             r_run;
   logic             r_en_d;
   logic [N_CH-1:0]  r_elig;
   sched_state_t     r_state;
   logic [2:0]       r_grant_id;
   logic [2:0]       r_last_grant;
   logic             r_busy;
   logic             r_tmo_err;
   logic [15:0]      r_frame_cnt;
   logic [TW-1:0]    r_tmo_cnt;

   logic             w_start_rise;
   logic             w_stop_rise;
   logic             w_en_rise;
   logic             w_en_fall;
   logic             w_owned;
   logic             w_arb_vld;
   logic [2:0]       w_arb_idx;
   logic [NUM_W-1:0] w_sel_rdnum;
   logic [DW-1:0]    w_sel_dat;

   assign w_start_rise = r_start_sync[1] & ~r_start_d;
   assign w_stop_rise  = r_stop_sync[1] & ~r_stop_d;
   assign w_en_rise    = fr_en_out & ~r_en_d;
   assign w_en_fall    = ~fr_en_out & r_en_d;

   // Stop wins when both synced controls rise in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_sync <= 2'b00;
         r_stop_sync  <= 2'b00;
         r_start_d    <= 1'b0;
         r_stop_d     <= 1'b0;
         r_run        <= 1'b0;
         r_en_d       <= 1'b0;
         r_elig       <= '0;
      end else begin
         r_start_sync <= {r_start_sync[0], start_en};
         r_stop_sync  <= {r_stop_sync[0], stop_en};
         r_start_d    <= r_start_sync[1];
         r_stop_d     <= r_stop_sync[1];
         r_en_d       <= fr_en_out;
         if (w_stop_rise) begin
            r_run <= 1'b0;
         end else if (w_start_rise) begin
            r_run <= 1'b1;
         end
         for (int i = 0; i < N_CH; i++) begin
            r_elig[i] <= ch_enable[i] && (16'(ch_rdnum[i*NUM_W +: NUM_W]) >= frame_length);
         end
      end
   end

   frame_rr_arb #(
      .N_CH (N_CH)
   ) u_arb (
      .i_req  (r_elig),
      .i_last (r_last_grant),
      .o_idx  (w_arb_idx),
      .o_vld  (w_arb_vld)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= 3'd0;
         r_last_grant <= 3'(N_CH - 1);
         r_busy       <= 1'b0;
         r_tmo_err    <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_tmo_cnt    <= '0;
      end else begin
         r_tmo_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_run) r_state <= ST_ARB;
            end
            ST_ARB: begin
               if (!r_run) begin
                  r_state <= ST_IDLE;
               end else if (w_arb_vld) begin
                  r_grant_id   <= w_arb_idx;
                  r_last_grant <= w_arb_idx;
                  r_tmo_cnt    <= '0;
                  r_state      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // last_grant already points at the abandoned channel, so the retry moves on.
               if (w_en_rise) begin
                  r_busy  <= 1'b1;
                  r_state <= ST_BUSY;
               end else if (r_tmo_cnt == TW'(TMO_CYC - 1)) begin
                  r_tmo_err <= 1'b1;
                  r_state   <= ST_ARB;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_en_fall) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
               r_state     <= r_run ? ST_ARB : ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_owned = (r_state == ST_GRANT) || (r_state == ST_BUSY);

   always_comb begin
      w_sel_rdnum = '0;
      w_sel_dat   = '0;
      ch_rdreq    = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (r_grant_id == 3'(i)) begin
            w_sel_rdnum = ch_rdnum[i*NUM_W +: NUM_W];
            w_sel_dat   = ch_dat[i*DW +: DW];
            ch_rdreq[i] = fr_rdacq && w_owned;
         end
      end
   end

   // A zero fill count outside GRANT/BUSY keeps the framer from starting on an unowned FIFO.
   assign fr_rdnum  = w_owned ? w_sel_rdnum : '0;
   assign fr_dat    = w_sel_dat;
   assign grant_id  = r_grant_id;
   assign busy      = r_busy;
   assign tmo_err   = r_tmo_err;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_frame_out_sched.sv
// Bench for frame_out_sched: plays the framer and the source FIFOs, checks against a rule-level model.
module tb_frame_out_sched;
   localparam int N_CH  = 4;
   localparam int DW    = 16;
   localparam int NUM_W = 13;
   localparam int TMO   = 16;

   logic                  clk;
   logic                  reset_n;
   logic                  start_en;
   logic                  stop_en;
   logic                  fr_rdacq;
   logic                  fr_en_out;
   logic [15:0]           frame_length;
   logic [N_CH-1:0]       ch_enable;
   logic [N_CH-1:0]       ch_rdreq;
   logic [N_CH*NUM_W-1:0] ch_rdnum;
   logic [N_CH*DW-1:0]    ch_dat;
   logic [NUM_W-1:0]      fr_rdnum;
   logic [DW-1:0]         fr_dat;
   logic [2:0]            grant_id;
   logic                  busy;
   logic                  tmo_err;
   logic [15:0]           frame_cnt;

   logic [NUM_W-1:0] rd  [N_CH];
   logic [DW-1:0]    dat [N_CH];
   int n_cmp;
   int n_err;
   int last_g;

   frame_out_sched #(
      .N_CH    (N_CH),
      .DW      (DW),
      .NUM_W   (NUM_W),
      .TMO_CYC (TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_en     (start_en),
      .stop_en      (stop_en),
      .frame_length (frame_length),
      .ch_enable    (ch_enable),
      .ch_rdnum     (ch_rdnum),
      .ch_dat       (ch_dat),
      .ch_rdreq     (ch_rdreq),
      .fr_rdacq     (fr_rdacq),
      .fr_en_out    (fr_en_out),
      .fr_rdnum     (fr_rdnum),
      .fr_dat       (fr_dat),
      .grant_id     (grant_id),
      .busy         (busy),
      .tmo_err      (tmo_err),
      .frame_cnt    (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      ch_rdnum = '0;
      ch_dat   = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_rdnum[i*NUM_W +: NUM_W] = rd[i];
         ch_dat[i*DW +: DW]         = dat[i];
      end
   end

   // Reference: which channel the next frame must go to, given the eligible set.
   function automatic int exp_next(input logic [3:0] el, input int last);
      int idx;
`ifdef FRAME_OUT_SCHED_STRICT_PRIO_EN
      for (int i = 0; i < 4; i++) if (el[2'(i)]) return i;
`else
      for (int k = 1; k <= 4; k++) begin
         idx = (last + k) % 4;
         if (el[2'(idx)]) return idx;
      end
`endif
      return -1;
   endfunction

   function automatic logic [3:0] model_elig();
      logic [3:0] el;
      for (int i = 0; i < 4; i++) el[i] = ch_enable[i] && (int'(rd[i]) >= int'(frame_length));
      return el;
   endfunction

   task automatic set_all(input int v);
      for (int i = 0; i < N_CH; i++) rd[i] = NUM_W'(v);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      start_en  = 1'b0;
      stop_en   = 1'b0;
      fr_en_out = 1'b0;
      fr_rdacq  = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      last_g  = N_CH - 1;
   endtask

   task automatic start_run();
      @(negedge clk);
      start_en = 1'b1;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (fr_rdnum != '0) ok = 1'b1;
      end
   endtask

   task automatic frame_cycle(input logic en, input logic ack);
      @(negedge clk);
      fr_en_out = en;
      fr_rdacq  = ack;
      for (int i = 0; i < N_CH; i++) dat[i] = DW'($urandom);
      #1;
   endtask

   task automatic end_frame();
      frame_cycle(1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic rand_cfg();
      int j;
      frame_length = 16'($urandom_range(1, 300));
      ch_enable    = 4'($urandom);
      for (int i = 0; i < N_CH; i++) rd[i] = NUM_W'($urandom_range(0, 400));
      j = $urandom_range(0, 3);
      ch_enable[2'(j)] = 1'b1;
      rd[2'(j)] = NUM_W'(int'(frame_length) + $urandom_range(0, 50));
   endtask

   task automatic test_reset();
      do_reset();
      fr_rdacq = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (ch_rdreq !== 4'b0) begin n_err++; $display("FAIL reset_rdreq: got %b want 0000", ch_rdreq); end
      n_cmp++; if (fr_rdnum !== '0) begin n_err++; $display("FAIL reset_rdnum: got %0d want 0", fr_rdnum); end
      n_cmp++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
      n_cmp++; if ({busy, tmo_err} !== 2'b00) begin n_err++; $display("FAIL reset_busy_tmo: got %b want 00", {busy, tmo_err}); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
      fr_rdacq = 1'b0;
   endtask

   task automatic test_round_robin();
      bit ok;
      int g;
      do_reset();
      frame_length = 16'd100;
      ch_enable    = 4'hF;
      set_all(200);
      start_run();
      for (int f = 0; f < 5; f++) begin
         g = exp_next(4'hF, last_g);
         wait_grant(ok);
         n_cmp++;
         if (!ok || grant_id !== 3'(g)) begin
            n_err++; $display("FAIL rr_grant frame %0d: got %0d (found=%0b) want %0d", f, grant_id, ok, g);
         end
         last_g = g;
         for (int c = 0; c < 8; c++) begin
            frame_cycle(1'b1, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (ch_rdreq !== (fr_rdacq ? 4'(1 << g) : 4'b0)) begin
               n_err++; $display("FAIL rr_rdreq: got %b ack=%0b want one-hot ch%0d", ch_rdreq, fr_rdacq, g);
            end
            n_cmp++;
            if (fr_dat !== dat[2'(g)] || fr_rdnum !== rd[2'(g)]) begin
               n_err++; $display("FAIL rr_forward: got dat %h rdnum %0d want %h %0d", fr_dat, fr_rdnum, dat[2'(g)], rd[2'(g)]);
            end
         end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rr_busy: got %0b want 1", busy); end
         end_frame();
         n_cmp++;
         if (frame_cnt !== 16'(f + 1) || busy !== 1'b0) begin
            n_err++; $display("FAIL rr_done: got frame_cnt %0d busy %0b want %0d 0", frame_cnt, busy, f + 1);
         end
      end
   endtask

   task automatic test_elig_mask();
      bit seen;
      bit found;
      do_reset();
      frame_length = 16'd100;
      rd[0] = 13'd50; rd[1] = 13'd99; rd[2] = 13'd200; rd[3] = 13'd0;
      ch_enable = 4'b1011;
      start_run();
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk); #1;
         if (fr_rdnum != '0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mask_no_grant: got grant ch%0d want none", grant_id); end
      @(negedge clk);
      ch_enable = 4'b1111;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         if (fr_rdnum != '0) found = 1'b1;
      end
      n_cmp++;
      if (!found || grant_id !== 3'd2 || fr_rdnum !== 13'd200) begin
         n_err++; $display("FAIL mask_grant: got ch%0d rdnum %0d found=%0b want ch2 200", grant_id, fr_rdnum, found);
      end
   endtask

   task automatic test_stop_mid_frame();
      bit ok;
      bit all_busy;
      bit regrant;
      do_reset();
      frame_length = 16'd100;
      ch_enable    = 4'hF;
      set_all(200);
      start_run();
      wait_grant(ok);
      n_cmp++; if (!ok || grant_id !== 3'(exp_next(4'hF, last_g))) begin n_err++; $display("FAIL stop_grant: got %0d found=%0b", grant_id, ok); end
      repeat (3) frame_cycle(1'b1, 1'b0);
      stop_en  = 1'b1;
      all_busy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         frame_cycle(1'b1, 1'($urandom_range(0, 1)));
         if (busy !== 1'b1) all_busy = 1'b0;
      end
      n_cmp++; if (all_busy !== 1'b1) begin n_err++; $display("FAIL stop_truncated: busy dropped mid-frame, want held"); end
      end_frame();
      n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL stop_frame_cnt: got %0d want 1", frame_cnt); end
      regrant = 1'b0;
      repeat (30) begin
         @(negedge clk); #1;
         if (fr_rdnum != '0 || busy) regrant = 1'b1;
      end
      n_cmp++; if (regrant !== 1'b0) begin n_err++; $display("FAIL stop_regrant: got grant after stop, want none"); end
      stop_en = 1'b0;
   endtask

   task automatic test_timeout();
      bit ok;
      int g;
      int pulses;
      int pos;
      do_reset();
      frame_length = 16'd100;
      ch_enable    = 4'hF;
      set_all(200);
      start_run();
      g = exp_next(4'hF, last_g);
      wait_grant(ok);
      n_cmp++; if (!ok || grant_id !== 3'(g)) begin n_err++; $display("FAIL tmo_first_grant: got %0d want %0d", grant_id, g); end
      last_g = g;
      pulses = 0;
      pos    = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk); #1;
         if (tmo_err) begin
            pulses++;
            if (pos < 0) pos = k;
         end
      end
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL tmo_pulse_count: got %0d want 1", pulses); end
      n_cmp++; if (pos !== TMO) begin n_err++; $display("FAIL tmo_pulse_pos: got cycle %0d want %0d", pos, TMO); end
      g = exp_next(4'hF, last_g);
      wait_grant(ok);
      n_cmp++; if (!ok || grant_id !== 3'(g)) begin n_err++; $display("FAIL tmo_next_grant: got %0d want %0d", grant_id, g); end
      last_g = g;
   endtask

   task automatic test_start_stop_same();
      bit seen;
      bit ok;
      do_reset();
      frame_length = 16'd100;
      ch_enable    = 4'hF;
      set_all(200);
      @(negedge clk);
      start_en = 1'b1;
      stop_en  = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk); #1;
         if (fr_rdnum != '0 || busy) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL same_edge_run: got grant, want run held at 0"); end
      @(negedge clk);
      start_en = 1'b0;
      stop_en  = 1'b0;
      repeat (4) @(negedge clk);
      start_en = 1'b1;
      wait_grant(ok);
      n_cmp++; if (!ok || grant_id !== 3'(exp_next(4'hF, last_g))) begin n_err++; $display("FAIL same_edge_restart: got %0d found=%0b", grant_id, ok); end
   endtask

   task automatic test_two_eligible();
      bit ok;
      int g;
      do_reset();
      frame_length = 16'd100;
      ch_enable    = 4'hF;
      rd[0] = 13'd200; rd[1] = 13'd10; rd[2] = 13'd10; rd[3] = 13'd200;
      start_run();
      for (int f = 0; f < 3; f++) begin
         g = exp_next(model_elig(), last_g);
         wait_grant(ok);
         n_cmp++; if (!ok || grant_id !== 3'(g)) begin n_err++; $display("FAIL two_elig frame %0d: got %0d want %0d", f, grant_id, g); end
         last_g = g;
         repeat (4) frame_cycle(1'b1, 1'b0);
         end_frame();
      end
   endtask

   task automatic test_random();
      bit ok;
      int g;
      int len;
      do_reset();
      rand_cfg();
      start_run();
      for (int f = 0; f < 25; f++) begin
         g = exp_next(model_elig(), last_g);
         wait_grant(ok);
         n_cmp++; if (!ok || grant_id !== 3'(g)) begin n_err++; $display("FAIL rand_grant frame %0d: got %0d (found=%0b) want %0d", f, grant_id, ok, g); end
         last_g = g;
         len = $urandom_range(2, 10);
         for (int c = 0; c < len; c++) begin
            frame_cycle(1'b1, 1'($urandom_range(0, 1)));
            if (c == len / 2) begin
               rand_cfg();
               #1;
            end
            n_cmp++; if (ch_rdreq !== (fr_rdacq ? 4'(1 << g) : 4'b0)) begin n_err++; $display("FAIL rand_rdreq: got %b ack=%0b ch%0d", ch_rdreq, fr_rdacq, g); end
            n_cmp++; if (fr_dat !== dat[2'(g)]) begin n_err++; $display("FAIL rand_dat: got %h want %h", fr_dat, dat[2'(g)]); end
            n_cmp++; if (fr_rdnum !== rd[2'(g)]) begin n_err++; $display("FAIL rand_rdnum: got %0d want %0d", fr_rdnum, rd[2'(g)]); end
         end
         end_frame();
         n_cmp++; if (frame_cnt !== 16'(f + 1)) begin n_err++; $display("FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, f + 1); end
      end
   endtask

   task automatic test_reset_busy();
      bit ok;
      do_reset();
      frame_length = 16'd100;
      ch_enable    = 4'hF;
      set_all(200);
      start_run();
      wait_grant(ok);
      repeat (3) frame_cycle(1'b1, 1'b0);
      end_frame();
      wait_grant(ok);
      repeat (3) frame_cycle(1'b1, 1'b1);
      n_cmp++; if (busy !== 1'b1 || frame_cnt !== 16'd1) begin n_err++; $display("FAIL rstbusy_pre: got busy %0b cnt %0d want 1 1", busy, frame_cnt); end
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (ch_rdreq !== 4'b0 || fr_rdnum !== '0) begin n_err++; $display("FAIL rstbusy_fwd: got rdreq %b rdnum %0d want 0 0", ch_rdreq, fr_rdnum); end
      n_cmp++; if (grant_id !== 3'd0 || busy !== 1'b0 || tmo_err !== 1'b0) begin n_err++; $display("FAIL rstbusy_ctl: got grant %0d busy %0b tmo %0b want 0", grant_id, busy, tmo_err); end
      n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rstbusy_cnt: got %0d want 0", frame_cnt); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      last_g       = N_CH - 1;
      frame_length = 16'd0;
      ch_enable    = '0;
      for (int i = 0; i < N_CH; i++) begin
         rd[i]  = '0;
         dat[i] = '0;
      end
      test_reset();
      test_round_robin();
      test_elig_mask();
      test_stop_mid_frame();
      test_timeout();
      test_start_stop_same();
      test_two_eligible();
      test_random();
      test_reset_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
